chan_arb: RTL and testbench
===========================

// Module: chan_arb
// PURPOSE
//  Round-robin collector of per-channel trigger blocks.
//  Each channel processor holds complete blocks in its output fifo and serves them through a give/have/dout port.
//  This block drains whole blocks from those ports, one channel at a time, onto a single 16-bit valid/ready stream.
//  The stream feeds the board event builder / GTP sender.
//  Blocks are never interleaved on the output.
// PARAMETERS
//  NCH   16   number of channel processors (1..64; channel number field is 6 bits)
//  TOUT  15   width of mid-block watchdog counter (abort after 2**TOUT-1 idle cycles)
// PORTS
//  clk        in   1        125MHz system clock; all logic on posedge
//  rst_n      in   1        synchronous reset, active low
//  give       out  NCH      one-hot request to channel i (never more than one bit set)
//  have       in   NCH      channel ack; combinational from give; dout valid when have
//  din        in   16*NCH   channel i data at din[16*i+15:16*i]
//  out_data   out  16       output word
//  out_valid  out  1        output word valid
//  out_ready  in   1        downstream accepts word when out_valid & out_ready
//  err        out  1        1-clk pulse on protocol error (bad CW, watchdog abort)
//  busy       out  1        high while a block is in progress (not ST_SCAN)
// BEHAVIOUR
//  Reset: give=0, out_valid=0, out_data=0, err=0, busy=0, ptr=0, state ST_SCAN, counters 0.
//  Output register: 1 deep; load allowed when lden = ~out_valid | out_ready.
//   Load happens in the cycle have[ptr]=1 & give[ptr]=1; out_valid rises the next cycle (latency 1).
//  give[ptr] = lden & (state != ST_ABORT); a word is consumed only when have[ptr] is high in the same cycle.
//  ST_SCAN: probe channel ptr.
//   - have=0: ptr <= (ptr==NCH-1) ? 0 : ptr+1, i.e. one channel probed per cycle.
//   - have=1 with CW bit15=1: forward the CW, latch rem <= CW[8:0], go ST_BODY.
//   - CW[8:0]==0: forward the CW only, advance ptr, stay in ST_SCAN.
//   - have=1 with bit15=0: consume and drop the word, pulse err, advance ptr, stay in ST_SCAN.
//  ST_BODY: on each consumed word, forward it and rem <= rem-1.
//   - Word with rem==1 consumed: advance ptr (round robin after the served channel), go ST_SCAN.
//   - Body words are forwarded unchecked.
//   - give held on the same channel throughout; no other channel is probed.
//   - Watchdog: counts cycles with give[ptr]=1 & have[ptr]=0; cleared on each consumed word.
//     At all-ones: pulse err, go ST_ABORT.
//  ST_ABORT: give=0 for 1 cycle.
//   - Drive one output word 16'hFFFF (abort marker) when lden.
//   - Advance ptr, go ST_SCAN.
//   - The truncated block is not completed on the output.
//  out_ready low: give drops in the same cycle (lden=0); state, rem and ptr hold. No word lost or duplicated.
//  Reset mid-block: immediate return to reset state. The channel's partially read block is abandoned, out_valid=0.
//  Width rules: rem 9 bits; ptr $clog2(NCH) bits; watchdog TOUT bits saturating.
// CONFIGURATION
//  CHAN_ARB_STAT_EN defined: adds ports stat_sel(in,6), stat_blk(out,32), stat_err(out,32).
//   - Per-channel counters of completed blocks and errors; 32-bit wrap-around.
//   - Reset by rst_n; readout registered, 1 clk after stat_sel.
//  Undefined: no stat ports, no counters; all other behaviour identical.
// STRUCTURE
//  Package chan_arb_pkg:
//   - state enum ST_SCAN/ST_BODY/ST_ABORT
//   - CW_FLAG=15, CW_LEN_MSB=8, ABORT_WORD=16'hFFFF
//  Sub-module chan_arb_stat: counter bank, instantiated only under CHAN_ARB_STAT_EN.
//  Main FSM, output register and watchdog stay in chan_arb.
// TESTING
//  1. Ch3 holds one block CW=8005 plus 5 words, out_ready=1.
//     -> 6 words out contiguously; give[3] high 6 cycles; ptr then 4.
//  2. Ch0 and ch1 each hold one block of length 3.
//     -> ch0 block fully out before ch1 CW; no interleave.
//  3. out_ready toggles 1/0 every cycle during a length-10 block.
//     -> 11 words out in order, none duplicated, give low whenever lden=0.
//  4. Ch5 has gets have=0 after 2 of 4 body words, TOUT=4.
//     -> err pulse after 15 idle cycles, FFFF emitted, ptr=6.
//  5. Ch2 presents word 0123 (bit15=0) in scan.
//     -> word dropped, err 1 clk, no output.
//  6. rst_n low mid-body on ch7.
//     -> next cycle give=0, out_valid=0, ptr=0, ST_SCAN.
//     With CHAN_ARB_STAT_EN: ch7 counters read 0.

Source files
------------

// File: rtl/chan_arb_pkg.sv
// Shared types and constants for the round-robin channel block collector.
package chan_arb_pkg;

   localparam int unsigned DW         = 16;
   localparam int unsigned LEN_W      = 9;
   localparam int unsigned SEL_W      = 6;
   localparam int unsigned STAT_W     = 32;
   localparam int unsigned CW_FLAG    = 15;
   localparam int unsigned CW_LEN_MSB = 8;
   localparam logic [DW-1:0] ABORT_WORD = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_BODY,
      ST_ABORT
   } state_t;

   // Control word layout as presented by a channel processor
   typedef struct packed {
      logic                  flag;
      logic [5:0]            rsvd;
      logic [CW_LEN_MSB:0]   len;
   } cw_t;

   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chan_arb_if.sv
// Channel give/have/din ports plus the 16-bit valid/ready output stream.
interface chan_arb_if #(
   parameter int unsigned NCH = 16
);
   import chan_arb_pkg::*;

   logic [NCH-1:0]    give;
   logic [NCH-1:0]    have;
   logic [DW*NCH-1:0] din;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output give, out_data, out_valid,
      input  have, din, out_ready
   );

   modport slave (
      input  give, out_data, out_valid,
      output have, din, out_ready
   );

endinterface

// File: rtl/chan_arb_stat.sv
// Per-channel completed-block and error counters with registered readout.
module chan_arb_stat
   import chan_arb_pkg::*;
#(
   parameter int unsigned NCH   = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PTR_W-1:0]  ch,
   input  logic              blk_inc,
   input  logic              err_inc,
   input  logic [SEL_W-1:0]  stat_sel,
   output logic [STAT_W-1:0] stat_blk,
   output logic [STAT_W-1:0] stat_err
);

   logic [STAT_W-1:0] blk_cnt [NCH];
   logic [STAT_W-1:0] err_cnt [NCH];
   logic              sel_ok;

   assign sel_ok = (32'(stat_sel) < NCH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            blk_cnt[i] <= '0;
            err_cnt[i] <= '0;
         end
         stat_blk <= '0;
         stat_err <= '0;
      end else begin
         if (blk_inc) blk_cnt[ch] <= blk_cnt[ch] + STAT_W'(1);
         if (err_inc) err_cnt[ch] <= err_cnt[ch] + STAT_W'(1);
         stat_blk <= sel_ok ? blk_cnt[PTR_W'(stat_sel)] : '0;
         stat_err <= sel_ok ? err_cnt[PTR_W'(stat_sel)] : '0;
      end
   end

endmodule

// File: rtl/chan_arb.sv
// Round-robin collector draining whole channel blocks onto one 16-bit stream.
// Optional per-channel statistics enabled with `define CHAN_ARB_STAT_EN.
module chan_arb
   import chan_arb_pkg::*;
#(
   parameter int unsigned NCH  = 16,
   parameter int unsigned TOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   chan_arb_if.master        bus,
   output logic              err,
   output logic              busy
`ifdef CHAN_ARB_STAT_EN
   ,
   input  logic [SEL_W-1:0]  stat_sel,
   output logic [STAT_W-1:0] stat_blk,
   output logic [STAT_W-1:0] stat_err
`endif
);

   localparam int unsigned       PTR_W    = ptr_width(NCH);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NCH - 1);
   localparam logic [TOUT-1:0]   WD_MAX   = '1;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_nxt;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [TOUT-1:0]   wd_q, wd_d, wd_inc;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;
   logic              busy_q;
   logic              en_q;
   logic              lden, give_on, have_cur, cons, blk_done;
   logic [DW-1:0]     din_cur;
   cw_t               cw;

   // en_q keeps give low during and for one cycle after reset
   assign lden     = ~out_valid_q | bus.out_ready;
   assign give_on  = en_q & lden & (state_q != ST_ABORT);
   assign have_cur = bus.have[ptr_q];
   assign cons     = give_on & have_cur;
   assign din_cur  = bus.din[DW*ptr_q +: DW];
   assign cw       = cw_t'(din_cur);
   assign ptr_nxt  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
   assign wd_inc   = (wd_q == WD_MAX) ? wd_q : wd_q + TOUT'(1);

   assign bus.give      = give_on ? (NCH'(1) << ptr_q) : '0;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign err           = err_q;
   assign busy          = busy_q;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      wd_d        = wd_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q & ~bus.out_ready;
      err_d       = 1'b0;
      blk_done    = 1'b0;
      unique case (state_q)
         ST_SCAN: begin
            if (give_on) begin
               if (!have_cur) begin
                  ptr_d = ptr_nxt;
               end else if (cw.flag) begin
                  out_data_d  = din_cur;
                  out_valid_d = 1'b1;
                  if (cw.len == '0) begin
                     ptr_d    = ptr_nxt;
                     blk_done = 1'b1;
                  end else begin
                     rem_d   = cw.len;
                     wd_d    = '0;
                     state_d = ST_BODY;
                  end
               end else begin
                  err_d = 1'b1;
                  ptr_d = ptr_nxt;
               end
            end
         end
         ST_BODY: begin
            if (cons) begin
               out_data_d  = din_cur;
               out_valid_d = 1'b1;
               rem_d       = rem_q - LEN_W'(1);
               wd_d        = '0;
               if (rem_q == LEN_W'(1)) begin
                  ptr_d    = ptr_nxt;
                  state_d  = ST_SCAN;
                  blk_done = 1'b1;
               end
            end else if (give_on) begin
               wd_d = wd_inc;
               if (wd_inc == WD_MAX) begin
                  err_d   = 1'b1;
                  state_d = ST_ABORT;
               end
            end
         end
         ST_ABORT: begin
            if (lden) begin
               out_data_d  = ABORT_WORD;
               out_valid_d = 1'b1;
               ptr_d       = ptr_nxt;
               wd_d        = '0;
               state_d     = ST_SCAN;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_SCAN;
         ptr_q       <= '0;
         rem_q       <= '0;
         wd_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         en_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         wd_q        <= wd_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         busy_q      <= (state_d != ST_SCAN);
         en_q        <= 1'b1;
      end
   end

`ifdef CHAN_ARB_STAT_EN
   chan_arb_stat #(
      .NCH   (NCH),
      .PTR_W (PTR_W)
   ) u_stat (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch       (ptr_q),
      .blk_inc  (blk_done),
      .err_inc  (err_d),
      .stat_sel (stat_sel),
      .stat_blk (stat_blk),
      .stat_err (stat_err)
   );
`else
   logic unused_stat;
   assign unused_stat = blk_done;
`endif

endmodule

// File: tb/tb_chan_arb.sv
// Directed bench for chan_arb: channel fifo models, output capture, scenario tasks.
module tb_chan_arb;
   import chan_arb_pkg::*;

   localparam int unsigned NCH  = 16;
   localparam int unsigned TOUT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic err, busy;
`ifdef CHAN_ARB_STAT_EN
   logic [5:0]  stat_sel = '0;
   logic [31:0] stat_blk, stat_err;
`endif

   chan_arb_if #(.NCH(NCH)) bus ();

   chan_arb #(.NCH(NCH), .TOUT(TOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master),
      .err   (err),
      .busy  (busy)
`ifdef CHAN_ARB_STAT_EN
      ,
      .stat_sel (stat_sel),
      .stat_blk (stat_blk),
      .stat_err (stat_err)
`endif
   );

   always #4 clk = ~clk;

   // Channel output fifos: have follows give combinationally while data remains
   logic [15:0] mem [NCH][32];
   int          wr  [NCH] = '{default: 0};
   int          rd  [NCH] = '{default: 0};

   always_comb begin
      bus.have = '0;
      bus.din  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd[i] < wr[i]) begin
            bus.have[i]        = bus.give[i];
            bus.din[16*i +: 16] = mem[i][rd[i][4:0]];
         end
      end
   end

   logic [15:0] got   [256];
   int          stamp [256];
   int          got_n = 0;
   int          cyc   = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NCH; i++)
         if (bus.give[i] && bus.have[i]) rd[i] <= rd[i] + 1;
      if (bus.out_valid && bus.out_ready) begin
         got[got_n[7:0]]   <= bus.out_data;
         stamp[got_n[7:0]] <= cyc;
         got_n             <= got_n + 1;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   function automatic int oh_idx(input logic [NCH-1:0] v);
      int r = -1;
      for (int i = 0; i < NCH; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic push(input int ch, input logic [15:0] w);
      mem[ch][wr[ch][4:0]] = w;
      wr[ch] = wr[ch] + 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (bus.give !== 16'h0000) begin n_bad++; $display("FAIL reset_give got=%h exp=0000", bus.give); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      n_vec++; if (bus.out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data got=%h exp=0000", bus.out_data); end
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.give !== 16'h0001) begin n_bad++; $display("FAIL reset_ptr0 give=%h exp=0001", bus.give); end
   endtask

   task automatic test_single_block();
      int base, run, nxt;
      bit seen, ended;
      logic [15:0] exp [6];
      exp[0] = 16'h8005;
      for (int k = 1; k < 6; k++) exp[k] = 16'h0300 + 16'(k);
      base = got_n; run = 0; nxt = -1; seen = 0; ended = 0;
      for (int k = 0; k < 6; k++) push(3, exp[k]);
      repeat (60) begin
         @(negedge clk);
         if (!ended) begin
            if (bus.give[3]) begin seen = 1; run++; end
            else if (seen && bus.give != '0) begin ended = 1; nxt = oh_idx(bus.give); end
         end
      end
      n_vec++; if (got_n - base !== 6) begin n_bad++; $display("FAIL single_count got=%0d exp=6", got_n - base); end
      for (int k = 0; k < 6; k++) begin
         n_vec++; if (got[base+k] !== exp[k]) begin n_bad++; $display("FAIL single_word%0d got=%h exp=%h", k, got[base+k], exp[k]); end
      end
      n_vec++; if (stamp[base+5] - stamp[base] !== 5) begin n_bad++; $display("FAIL single_contig span=%0d exp=5", stamp[base+5] - stamp[base]); end
      n_vec++; if (run !== 6) begin n_bad++; $display("FAIL single_give3 cycles=%0d exp=6", run); end
      n_vec++; if (nxt !== 4) begin n_bad++; $display("FAIL single_ptr got=%0d exp=4", nxt); end
   endtask

   task automatic test_two_channels();
      int base, t;
      logic [15:0] exp [8];
      exp = '{16'h8003, 16'h0101, 16'h0102, 16'h0103, 16'h8003, 16'h0201, 16'h0202, 16'h0203};
      t = 0;
      while (!bus.give[2] && t < 40) begin @(negedge clk); t++; end
      n_vec++; if (!bus.give[2]) begin n_bad++; $display("FAIL two_wait_ptr2 give=%h exp=0004", bus.give); end
      base = got_n;
      for (int k = 0; k < 4; k++) push(0, exp[k]);
      for (int k = 4; k < 8; k++) push(1, exp[k]);
      t = 0;
      while (got_n - base < 8 && t < 100) begin @(negedge clk); t++; end
      repeat (5) @(negedge clk);
      n_vec++; if (got_n - base !== 8) begin n_bad++; $display("FAIL two_count got=%0d exp=8", got_n - base); end
      for (int k = 0; k < 8; k++) begin
         n_vec++; if (got[base+k] !== exp[k]) begin n_bad++; $display("FAIL two_word%0d got=%h exp=%h", k, got[base+k], exp[k]); end
      end
   endtask

   task automatic test_backpressure();
      int base, viol, nlow;
      base = got_n; viol = 0; nlow = 0;
      push(9, 16'h800A);
      for (int k = 1; k <= 10; k++) push(9, 16'h0900 + 16'(k));
      repeat (120) begin
         @(negedge clk);
         bus.out_ready = ~bus.out_ready;
         #1;
         if (bus.out_valid && !bus.out_ready) begin
            nlow++;
            if (bus.give != '0) viol++;
         end
      end
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++; if (viol !== 0) begin n_bad++; $display("FAIL bp_give_when_stalled cycles=%0d exp=0", viol); end
      n_vec++; if (nlow == 0) begin n_bad++; $display("FAIL bp_no_stall_seen stalls=%0d exp=>0", nlow); end
      n_vec++; if (got_n - base !== 11) begin n_bad++; $display("FAIL bp_count got=%0d exp=11", got_n - base); end
      n_vec++; if (got[base] !== 16'h800A) begin n_bad++; $display("FAIL bp_cw got=%h exp=800a", got[base]); end
      for (int k = 1; k <= 10; k++) begin
         n_vec++; if (got[base+k] !== 16'h0900 + 16'(k)) begin n_bad++; $display("FAIL bp_word%0d got=%h exp=%h", k, got[base+k], 16'h0900 + 16'(k)); end
      end
   endtask

   task automatic test_watchdog();
      int base, idle, nerr, nxt;
      bit started, err_seen;
      logic [15:0] exp [4];
      exp = '{16'h8004, 16'h0501, 16'h0502, 16'hFFFF};
      base = got_n; idle = 0; nerr = 0; nxt = -1; started = 0; err_seen = 0;
      for (int k = 0; k < 3; k++) push(5, exp[k]);
      repeat (80) begin
         @(negedge clk);
         if (err) nerr++;
         if (bus.give[5] && bus.have[5]) started = 1;
         if (err) err_seen = 1;
         else if (started && !err_seen && bus.give[5] && !bus.have[5]) idle++;
         else if (err_seen && nxt < 0 && bus.give != '0) nxt = oh_idx(bus.give);
      end
      n_vec++; if (idle !== 15) begin n_bad++; $display("FAIL wd_idle_cycles got=%0d exp=15", idle); end
      n_vec++; if (nerr !== 1) begin n_bad++; $display("FAIL wd_err_pulse cycles=%0d exp=1", nerr); end
      n_vec++; if (nxt !== 6) begin n_bad++; $display("FAIL wd_ptr got=%0d exp=6", nxt); end
      n_vec++; if (got_n - base !== 4) begin n_bad++; $display("FAIL wd_count got=%0d exp=4", got_n - base); end
      for (int k = 0; k < 4; k++) begin
         n_vec++; if (got[base+k] !== exp[k]) begin n_bad++; $display("FAIL wd_word%0d got=%h exp=%h", k, got[base+k], exp[k]); end
      end
   endtask

   task automatic test_bad_cw();
      int base, nerr, nbusy;
      base = got_n; nerr = 0; nbusy = 0;
`ifdef CHAN_ARB_STAT_EN
      stat_sel = 6'd2;
`endif
      push(2, 16'h0123);
      repeat (40) begin
         @(negedge clk);
         if (err) nerr++;
         if (busy) nbusy++;
      end
      n_vec++; if (nerr !== 1) begin n_bad++; $display("FAIL badcw_err cycles=%0d exp=1", nerr); end
      n_vec++; if (got_n - base !== 0) begin n_bad++; $display("FAIL badcw_output words=%0d exp=0", got_n - base); end
      n_vec++; if (rd[2] !== wr[2]) begin n_bad++; $display("FAIL badcw_dropped left=%0d exp=0", wr[2] - rd[2]); end
      n_vec++; if (nbusy !== 0) begin n_bad++; $display("FAIL badcw_busy cycles=%0d exp=0", nbusy); end
`ifdef CHAN_ARB_STAT_EN
      n_vec++; if (stat_err !== 32'd1) begin n_bad++; $display("FAIL badcw_stat_err got=%0d exp=1", stat_err); end
      n_vec++; if (stat_blk !== 32'd0) begin n_bad++; $display("FAIL badcw_stat_blk got=%0d exp=0", stat_blk); end
`endif
   endtask

   task automatic test_zero_len();
      int base, nerr, nbusy;
      base = got_n; nerr = 0; nbusy = 0;
      push(10, 16'h8000);
      repeat (40) begin
         @(negedge clk);
         if (err) nerr++;
         if (busy) nbusy++;
      end
      n_vec++; if (got_n - base !== 1) begin n_bad++; $display("FAIL zlen_count got=%0d exp=1", got_n - base); end
      n_vec++; if (got[base] !== 16'h8000) begin n_bad++; $display("FAIL zlen_word got=%h exp=8000", got[base]); end
      n_vec++; if (nbusy !== 0) begin n_bad++; $display("FAIL zlen_busy cycles=%0d exp=0", nbusy); end
      n_vec++; if (nerr !== 0) begin n_bad++; $display("FAIL zlen_err cycles=%0d exp=0", nerr); end
   endtask

   task automatic test_reset_mid();
      int base, t;
      base = got_n;
      push(7, 16'h8008);
      for (int k = 1; k <= 8; k++) push(7, 16'h0700 + 16'(k));
      t = 0;
      while (got_n - base < 3 && t < 60) begin @(negedge clk); t++; end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
      rst_n = 1'b0;
`ifdef CHAN_ARB_STAT_EN
      stat_sel = 6'd7;
`endif
      @(negedge clk);
      n_vec++; if (bus.give !== 16'h0000) begin n_bad++; $display("FAIL rstmid_give got=%h exp=0000", bus.give); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.give !== 16'h0001) begin n_bad++; $display("FAIL rstmid_ptr0 give=%h exp=0001", bus.give); end
`ifdef CHAN_ARB_STAT_EN
      n_vec++; if (stat_blk !== 32'd0) begin n_bad++; $display("FAIL rstmid_stat_blk got=%0d exp=0", stat_blk); end
      n_vec++; if (stat_err !== 32'd0) begin n_bad++; $display("FAIL rstmid_stat_err got=%0d exp=0", stat_err); end
`endif
   endtask

   initial begin
      bus.out_ready = 1'b1;
      test_reset();
      test_single_block();
      test_two_channels();
      test_backpressure();
      test_watchdog();
      test_bad_cw();
      test_zero_len();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
